// File: rtl/trigger_detector_if.sv
// Control, sample-stream and trigger-status signals between the acquisition logic
// and one trigger_detector channel.
interface trigger_detector_if;
  logic       arm;
  logic       abort;
  logic       sample_valid;
  logic [7:0] sample;
  logic [7:0] ref_level;
  logic [3:0] hysteresis;
  logic       slope;
  logic       auto_mode;
  logic       trigger;
  logic       trig_armed;
  logic       trig_forced;
  logic [7:0] trig_sample;

  modport master (
    output arm, abort, sample_valid, sample, ref_level, hysteresis, slope, auto_mode,
    input  trigger, trig_armed, trig_forced, trig_sample
  );

  modport slave (
    input  arm, abort, sample_valid, sample, ref_level, hysteresis, slope, auto_mode,
    output trigger, trig_armed, trig_forced, trig_sample
  );
endinterface

// File: rtl/trigger_detector.sv
// Single-shot level trigger with slope select, hysteresis pre-arm band, auto-timeout
// forced trigger and post-fire holdoff during which re-arm is ignored.
module trigger_detector #(
  parameter int AUTO_TIMEOUT   = 5_000_000,
  parameter int HOLDOFF_CYCLES = 1024
) (
  input  logic               clk_50,
  input  logic               reset_n,
  trigger_detector_if.slave  bus
);

  localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);
  localparam int HLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(AUTO_TIMEOUT);
  localparam logic [HLD_W-1:0] HLD_DONE = HLD_W'(HOLDOFF_CYCLES);

  typedef enum logic [2:0] {IDLE, PRE, READY, FIRE, HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMO_W-1:0] r_tmo;
  logic [HLD_W-1:0] r_hold;
  logic             r_trigger;
  logic             r_armed;
  logic             r_forced;
  logic [7:0]       r_trig_sample;

  logic [7:0] w_lo;
  logic [7:0] w_hi;
  logic       w_pre_ok;
  logic       w_cross;
  logic       w_tmo_hit;
  logic       w_fire_real;
  logic       w_fire_forced;
  logic       w_arm_accept;

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {5'b0, b};
    return d[8] ? 8'h00 : d[7:0];
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign w_lo      = sat_sub(bus.ref_level, bus.hysteresis);
  assign w_hi      = sat_add(bus.ref_level, bus.hysteresis);
  assign w_pre_ok  = bus.sample_valid && (bus.slope ? (bus.sample >= w_hi) : (bus.sample <= w_lo));
  assign w_cross   = bus.sample_valid && (bus.slope ? (bus.sample <= bus.ref_level)
                                                    : (bus.sample >= bus.ref_level));
  assign w_tmo_hit = bus.auto_mode && (r_tmo == TMO_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_fire_real   = 1'b0;
    w_fire_forced = 1'b0;
    w_arm_accept  = 1'b0;
    unique case (r_state)
      IDLE: if (bus.arm) begin
        w_state_nxt  = PRE;
        w_arm_accept = 1'b1;
      end
      PRE: begin
        if (bus.arm) begin
          w_state_nxt  = PRE;
          w_arm_accept = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt   = FIRE;
          w_fire_forced = 1'b1;
        end else if (w_pre_ok) begin
          w_state_nxt = READY;
        end
      end
      READY: begin
        // A real crossing wins over a timeout landing on the same cycle.
        if (bus.arm) begin
          w_state_nxt  = PRE;
          w_arm_accept = 1'b1;
        end else if (w_cross) begin
          w_state_nxt = FIRE;
          w_fire_real = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt   = FIRE;
          w_fire_forced = 1'b1;
        end
      end
      FIRE: w_state_nxt = HOLD;
      HOLD: if (bus.arm && (r_hold == HLD_DONE)) begin
        w_state_nxt  = PRE;
        w_arm_accept = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (bus.abort) begin
      w_state_nxt   = IDLE;
      w_fire_real   = 1'b0;
      w_fire_forced = 1'b0;
      w_arm_accept  = 1'b0;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_tmo   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arm_accept)
        r_tmo <= '0;
      else if (((r_state == PRE) || (r_state == READY)) && bus.auto_mode && (r_tmo != TMO_MAX))
        r_tmo <= r_tmo + 1'b1;
      if (r_state == FIRE)
        r_hold <= '0;
      else if ((r_state == HOLD) && (r_hold != HLD_DONE))
        r_hold <= r_hold + 1'b1;
    end
  end

  // Status outputs are registered alongside the state so they line up with it.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_trigger     <= 1'b0;
      r_armed       <= 1'b0;
      r_forced      <= 1'b0;
      r_trig_sample <= 8'h00;
    end else begin
      r_trigger <= (w_state_nxt == FIRE);
      r_armed   <= (w_state_nxt == PRE) || (w_state_nxt == READY);
      if (w_fire_real) begin
        r_forced      <= 1'b0;
        r_trig_sample <= bus.sample;
      end else if (w_fire_forced) begin
        r_forced      <= 1'b1;
        r_trig_sample <= 8'h00;
      end else if (w_arm_accept) begin
        r_forced <= 1'b0;
      end
    end
  end

  assign bus.trigger     = r_trigger;
  assign bus.trig_armed  = r_armed;
  assign bus.trig_forced = r_forced;
  assign bus.trig_sample = r_trig_sample;

endmodule

// File: tb/tb_trigger_detector.sv
// Directed-vector bench for trigger_detector with a short timeout and holdoff.
module tb_trigger_detector;
  localparam int TMO = 16;
  localparam int HLD = 8;

  logic clk_50  = 1'b0;
  logic reset_n = 1'b0;
  int   pass_cnt = 0;
  int   total    = 0;

  trigger_detector_if bus ();

  trigger_detector #(.AUTO_TIMEOUT(TMO), .HOLDOFF_CYCLES(HLD)) dut (
    .clk_50 (clk_50),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk_50 = ~clk_50;

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic step(input logic a, input logic ab, input logic v, input logic [7:0] s);
    bus.arm = a; bus.abort = ab; bus.sample_valid = v; bus.sample = s;
    tick();
    bus.arm = 1'b0; bus.abort = 1'b0; bus.sample_valid = 1'b0;
  endtask

  task automatic wait_holdoff();
    repeat (HLD + 4) tick();
  endtask

  task automatic test_reset();
    #12;
    total++; if (bus.trigger !== 1'b0) $display("FAIL rst_trigger got %b exp 0", bus.trigger); else pass_cnt++;
    total++; if (bus.trig_armed !== 1'b0) $display("FAIL rst_armed got %b exp 0", bus.trig_armed); else pass_cnt++;
    total++; if (bus.trig_forced !== 1'b0) $display("FAIL rst_forced got %b exp 0", bus.trig_forced); else pass_cnt++;
    total++; if (bus.trig_sample !== 8'h00) $display("FAIL rst_sample got %0d exp 0", bus.trig_sample); else pass_cnt++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_rising();
    bus.slope = 1'b0; bus.ref_level = 8'd128; bus.hysteresis = 4'd4;
    step(1, 0, 0, 0);
    total++; if (bus.trig_armed !== 1'b1) $display("FAIL t1_armed got %b exp 1", bus.trig_armed); else pass_cnt++;
    step(0, 0, 1, 8'd100);
    step(0, 0, 1, 8'd124);
    total++; if (bus.trigger !== 1'b0) $display("FAIL t1_early got %b exp 0", bus.trigger); else pass_cnt++;
    step(0, 0, 1, 8'd130);
    total++; if (bus.trigger !== 1'b1) $display("FAIL t1_fire got %b exp 1", bus.trigger); else pass_cnt++;
    total++; if (bus.trig_sample !== 8'd130) $display("FAIL t1_sample got %0d exp 130", bus.trig_sample); else pass_cnt++;
    total++; if (bus.trig_armed !== 1'b0) $display("FAIL t1_armed_fire got %b exp 0", bus.trig_armed); else pass_cnt++;
    step(0, 0, 0, 0);
    total++; if (bus.trigger !== 1'b0) $display("FAIL t1_pulse_len got %b exp 0", bus.trigger); else pass_cnt++;
    wait_holdoff();
  endtask

  task automatic test_no_prearm();
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'd126);
    step(0, 0, 1, 8'd127);
    step(0, 0, 1, 8'd130);
    total++; if (bus.trigger !== 1'b0) $display("FAIL t2_trigger got %b exp 0", bus.trigger); else pass_cnt++;
    step(0, 0, 0, 0);
    total++; if (bus.trigger !== 1'b0) $display("FAIL t2_trigger_late got %b exp 0", bus.trigger); else pass_cnt++;
    total++; if (bus.trig_armed !== 1'b1) $display("FAIL t2_armed got %b exp 1", bus.trig_armed); else pass_cnt++;
    step(0, 1, 0, 0);
    total++; if (bus.trig_armed !== 1'b0) $display("FAIL t2_abort got %b exp 0", bus.trig_armed); else pass_cnt++;
  endtask

  task automatic test_falling_sat();
    bus.slope = 1'b1; bus.ref_level = 8'd250; bus.hysteresis = 4'd10;
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'd254);
    step(0, 0, 1, 8'd200);
    total++; if (bus.trigger !== 1'b0) $display("FAIL t3_below_hi got %b exp 0", bus.trigger); else pass_cnt++;
    step(0, 0, 1, 8'd255);
    step(0, 0, 1, 8'd200);
    total++; if (bus.trigger !== 1'b1) $display("FAIL t3_fire got %b exp 1", bus.trigger); else pass_cnt++;
    total++; if (bus.trig_sample !== 8'd200) $display("FAIL t3_sample got %0d exp 200", bus.trig_sample); else pass_cnt++;
    total++; if (bus.trig_forced !== 1'b0) $display("FAIL t3_forced got %b exp 0", bus.trig_forced); else pass_cnt++;
    wait_holdoff();
  endtask

  task automatic test_auto();
    int cnt;
    cnt = 0;
    bus.slope = 1'b0; bus.ref_level = 8'd128; bus.hysteresis = 4'd4; bus.auto_mode = 1'b1;
    step(1, 0, 0, 0);
    bus.sample = 8'd128; bus.sample_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.trigger === 1'b1) begin
        cnt = k;
        break;
      end
    end
    bus.sample_valid = 1'b0;
    total++; if (cnt != TMO) $display("FAIL t4_latency got %0d exp %0d", cnt, TMO); else pass_cnt++;
    total++; if (bus.trig_forced !== 1'b1) $display("FAIL t4_forced got %b exp 1", bus.trig_forced); else pass_cnt++;
    total++; if (bus.trig_sample !== 8'h00) $display("FAIL t4_sample got %0d exp 0", bus.trig_sample); else pass_cnt++;
    wait_holdoff();
  endtask

  task automatic test_cross_vs_timeout();
    step(1, 0, 0, 0);
    total++; if (bus.trig_forced !== 1'b0) $display("FAIL t7_forced_clr got %b exp 0", bus.trig_forced); else pass_cnt++;
    step(0, 0, 1, 8'd100);
    repeat (TMO - 2) tick();
    total++; if (bus.trigger !== 1'b0) $display("FAIL t7_early got %b exp 0", bus.trigger); else pass_cnt++;
    step(0, 0, 1, 8'd130);
    total++; if (bus.trigger !== 1'b1) $display("FAIL t7_fire got %b exp 1", bus.trigger); else pass_cnt++;
    total++; if (bus.trig_forced !== 1'b0) $display("FAIL t7_forced got %b exp 0", bus.trig_forced); else pass_cnt++;
    total++; if (bus.trig_sample !== 8'd130) $display("FAIL t7_sample got %0d exp 130", bus.trig_sample); else pass_cnt++;
    bus.auto_mode = 1'b0;
    wait_holdoff();
  endtask

  task automatic test_rearm();
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'd100);
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'd130);
    total++; if (bus.trigger !== 1'b0) $display("FAIL t8_restart got %b exp 0", bus.trigger); else pass_cnt++;
    step(0, 0, 1, 8'd100);
    step(0, 0, 1, 8'd130);
    total++; if (bus.trigger !== 1'b1) $display("FAIL t8_fire got %b exp 1", bus.trigger); else pass_cnt++;
    wait_holdoff();
  endtask

  task automatic test_abort_holdoff();
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'd100);
    step(0, 1, 1, 8'd130);
    total++; if (bus.trigger !== 1'b0) $display("FAIL t5_abort_trig got %b exp 0", bus.trigger); else pass_cnt++;
    total++; if (bus.trig_armed !== 1'b0) $display("FAIL t5_abort_idle got %b exp 0", bus.trig_armed); else pass_cnt++;
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'd100);
    step(0, 0, 1, 8'd130);
    total++; if (bus.trigger !== 1'b1) $display("FAIL t5_fire got %b exp 1", bus.trigger); else pass_cnt++;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    total++; if (bus.trig_armed !== 1'b0) $display("FAIL t5_hold_arm got %b exp 0", bus.trig_armed); else pass_cnt++;
    wait_holdoff();
    step(1, 0, 0, 0);
    total++; if (bus.trig_armed !== 1'b1) $display("FAIL t5_late_arm got %b exp 1", bus.trig_armed); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'd100);
    total++; if (bus.trig_armed !== 1'b1) $display("FAIL t6_ready got %b exp 1", bus.trig_armed); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus.trig_armed !== 1'b0) $display("FAIL t6_armed got %b exp 0", bus.trig_armed); else pass_cnt++;
    total++; if (bus.trig_sample !== 8'h00) $display("FAIL t6_sample got %0d exp 0", bus.trig_sample); else pass_cnt++;
    total++; if (bus.trig_forced !== 1'b0) $display("FAIL t6_forced got %b exp 0", bus.trig_forced); else pass_cnt++;
    tick();
    reset_n = 1'b1;
    tick();
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'd100);
    step(0, 0, 1, 8'd140);
    total++; if (bus.trigger !== 1'b1) $display("FAIL t6_fire got %b exp 1", bus.trigger); else pass_cnt++;
    total++; if (bus.trig_sample !== 8'd140) $display("FAIL t6_fire_sample got %0d exp 140", bus.trig_sample); else pass_cnt++;
  endtask

  initial begin
    bus.arm = 1'b0; bus.abort = 1'b0; bus.sample_valid = 1'b0; bus.sample = 8'h00;
    bus.ref_level = 8'd128; bus.hysteresis = 4'd4; bus.slope = 1'b0; bus.auto_mode = 1'b0;
    test_reset();
    test_rising();
    test_no_prearm();
    test_falling_sat();
    test_auto();
    test_cross_vs_timeout();
    test_rearm();
    test_abort_holdoff();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
